// File: rtl/light_tx_scheduler_pkg.sv
// Shared definitions for the optical transmit scheduler: state encoding and defaults.
// No logic of its own; latency not applicable.
// No flow control; constants and types only.
package light_tx_scheduler_pkg;

  localparam int PACKET_SIZE_DEF   = 8;
  localparam int TX_GAP_CYCLES     = 4;
  localparam int TX_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/light_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first set request scanning upward from the pointer, with wrap.
// Combinational winner; pointer moves on the edge where accept_i is high.
// No backpressure; the caller decides when a pick is consumed via accept_i.
module light_tx_scheduler_rr_arbiter
  import light_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = id_width(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic               vld_o,
  output logic [IDW-1:0]     idx_o
);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] ptr_d;
  logic [IDW-1:0] cand;

  // base + off modulo NUM_REQ; off never exceeds NUM_REQ so one subtraction suffices.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Scan downward in distance so the closest set bit after the pointer is the last writer.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = wrap_add(ptr_q, k);
      if (req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

  // Pointer lands just past the accepted winner so it gets lowest priority next round.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = wrap_add(idx_o, 1);
  end

  // Pointer register.
  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/light_tx_scheduler.sv
// Shares one optical encoder between NUM_REQ requesters: round-robin grant, gap, timeout.
// Grant and enc_start rise one cycle after a request is seen in IDLE.
// Requests wait (held high) while busy; the encoder cannot stall us beyond TIMEOUT_CYCLES.
module light_tx_scheduler
  import light_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PACKET_SIZE    = PACKET_SIZE_DEF,
  parameter int GAP_CYCLES     = TX_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = TX_TIMEOUT_CYCLES,
  localparam int IDW = id_width(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PACKET_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [PACKET_SIZE-1:0]         enc_data,
  output logic                           enc_start,
  input  logic                           enc_done,
  output logic                           busy,
  output logic [IDW-1:0]                 active_id,
  output logic                           timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  tx_state_t               state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic                    enc_start_q, enc_start_d;
  logic [PACKET_SIZE-1:0]  enc_data_q, enc_data_d;
  logic [IDW-1:0]          active_id_q, active_id_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [GW-1:0]           gcnt_q, gcnt_d;

  logic                    arb_vld;
  logic [IDW-1:0]          arb_idx;
  logic                    arb_accept;
  logic [PACKET_SIZE-1:0]  win_pkt;

  light_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clock    (clock),
    .reset    (reset),
    .req_i    (req),
    .accept_i (arb_accept),
    .vld_o    (arb_vld),
    .idx_o    (arb_idx)
  );

  // Pick the winning requester's packet slice.
  always_comb begin
    win_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDW'(i)) win_pkt = req_data[i*PACKET_SIZE +: PACKET_SIZE];
    end
  end

  // Next state and registered outputs; pulses default low, data/id hold.
  always_comb begin
    state_d       = state_q;
    grant_d       = '0;
    enc_start_d   = 1'b0;
    enc_data_d    = enc_data_q;
    active_id_d   = active_id_q;
    timeout_err_d = 1'b0;
    tcnt_d        = tcnt_q;
    gcnt_d        = gcnt_q;
    arb_accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          state_d     = ST_SEND;
          grant_d     = NUM_REQ'(1) << arb_idx;
          enc_start_d = 1'b1;
          enc_data_d  = win_pkt;
          active_id_d = arb_idx;
          tcnt_d      = '0;
          arb_accept  = 1'b1;
        end
      end
      ST_SEND: begin
        // Done beats a simultaneous timeout, so no error is flagged in that case.
        if (enc_done) begin
          state_d = ST_GAP;
          gcnt_d  = '0;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_GAP;
          gcnt_d        = '0;
          timeout_err_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        // Requests and done are ignored here so the decoder can re-synchronise.
        if (gcnt_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else                              gcnt_d  = gcnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset from any state without notifying the encoder.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      enc_start_q   <= 1'b0;
      enc_data_q    <= '0;
      active_id_q   <= '0;
      timeout_err_q <= 1'b0;
      tcnt_q        <= '0;
      gcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      enc_start_q   <= enc_start_d;
      enc_data_q    <= enc_data_d;
      active_id_q   <= active_id_d;
      timeout_err_q <= timeout_err_d;
      tcnt_q        <= tcnt_d;
      gcnt_q        <= gcnt_d;
    end
  end

  assign grant       = grant_q;
  assign enc_start   = enc_start_q;
  assign enc_data    = enc_data_q;
  assign active_id   = active_id_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_light_tx_scheduler.sv
// Bench for the optical transmit scheduler: scenario tasks against a transaction model.
// Model tracks the round-robin pointer and the done-to-start timing rules.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_light_tx_scheduler;

  localparam int N = 4;
  localparam int W = 8;
  localparam int G = 4;
  localparam int T = 64;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           enc_done;
  logic [N-1:0]   grant;
  logic [W-1:0]   enc_data;
  logic           enc_start;
  logic           busy;
  logic [1:0]     active_id;
  logic           timeout_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [1:0] mptr;
  logic [W-1:0] pkt [N];

  light_tx_scheduler #(
    .NUM_REQ(N), .PACKET_SIZE(W), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .enc_data(enc_data), .enc_start(enc_start),
    .enc_done(enc_done), .busy(busy), .active_id(active_id),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Grant must be at most one-hot and always paired with enc_start.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      n_vec++;
      if (((grant != '0) !== enc_start) || ($countones(grant) > 1)) begin
        n_err++;
        $display("FAIL grant_start_pair: grant=%b enc_start=%b", grant, enc_start);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic load_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = pkt[i];
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = '0; enc_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    mptr = 2'd0;
  endtask

  // Reference rule: first requester at or after the pointer, wrapping modulo 4.
  function automatic logic [1:0] pick(input logic [N-1:0] r, input logic [1:0] p);
    logic found;
    logic [1:0] j;
    found = 1'b0;
    pick = p;
    for (int k = 0; k < N; k++) begin
      j = p + 2'(k);
      if (!found && r[j]) begin pick = j; found = 1'b1; end
    end
  endfunction

  task automatic wait_start(input int budget, output bit got);
    int i;
    i = 0;
    while (enc_start !== 1'b1 && i < budget) begin tick(); i++; end
    got = (enc_start === 1'b1);
  endtask

  task automatic test_reset();
    logic [N-1:0] g;
    reset = 1'b1; req = '0; enc_done = 1'b0;
    for (int i = 0; i < N; i++) pkt[i] = W'($urandom);
    load_data();
    tick(); tick();
    g = grant;
    n_vec++; if (g !== 4'b0) begin n_err++; $display("FAIL rst_grant: got %b want 0000", g); end
    n_vec++; if (enc_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", enc_start); end
    n_vec++; if (enc_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", enc_data); end
    n_vec++; if (active_id !== 2'd0) begin n_err++; $display("FAIL rst_id: got %0d want 0", active_id); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset = 1'b0;
    mptr = 2'd0;
  endtask

  task automatic test_single();
    int d;
    apply_reset();
    pkt[0] = 8'hB6; load_data();
    req = 4'b0001;
    tick();
    n_vec++; if (enc_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b want 1", enc_start); end
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", grant); end
    n_vec++; if (enc_data !== 8'hB6) begin n_err++; $display("FAIL single_data: got %h want b6", enc_data); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    req = '0; mptr = 2'd1;
    repeat (20) tick();
    n_vec++; if (enc_data !== 8'hB6) begin n_err++; $display("FAIL single_hold: got %h want b6", enc_data); end
    enc_done = 1'b1; d = cyc;
    tick(); enc_done = 1'b0;
    repeat (G - 1) tick();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_gap_busy: got %b want 1 at done+%0d", busy, cyc - d); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0 at done+%0d", busy, cyc - d); end
  endtask

  task automatic test_all();
    bit got;
    int prev;
    logic [1:0] e;
    apply_reset();
    pkt[0] = 8'hA1; pkt[1] = 8'hB2; pkt[2] = 8'hC3; pkt[3] = 8'hD4; load_data();
    req = 4'b1111;
    prev = -1;
    for (int k = 0; k < N; k++) begin
      e = pick(req, mptr);
      wait_start(40, got);
      n_vec++; if (!got) begin n_err++; $display("FAIL all_start: no enc_start within budget, want grant to %0d", e); end
      n_vec++; if (grant !== (4'b0001 << e)) begin n_err++; $display("FAIL all_grant: got %b want id %0d", grant, e); end
      n_vec++; if (active_id !== e) begin n_err++; $display("FAIL all_id: got %0d want %0d", active_id, e); end
      n_vec++; if (enc_data !== pkt[e]) begin n_err++; $display("FAIL all_data: got %h want %h", enc_data, pkt[e]); end
      if (prev >= 0) begin
        n_vec++; if (cyc - prev != 10 + G + 2) begin n_err++; $display("FAIL all_spacing: got %0d want %0d", cyc - prev, 10 + G + 2); end
      end
      prev = cyc; req[e] = 1'b0; mptr = e + 2'd1;
      repeat (10) tick();
      enc_done = 1'b1; tick(); enc_done = 1'b0;
    end
  endtask

  task automatic test_fairness();
    bit got;
    logic [1:0] e;
    apply_reset();
    for (int i = 0; i < N; i++) pkt[i] = W'($urandom);
    load_data();
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      e = pick(req, mptr);
      wait_start(40, got);
      n_vec++; if (!got || grant !== (4'b0001 << e)) begin n_err++; $display("FAIL fair_grant%0d: got %b want id %0d", k, grant, e); end
      n_vec++; if (enc_data !== pkt[e]) begin n_err++; $display("FAIL fair_data%0d: got %h want %h", k, enc_data, pkt[e]); end
      if (e != 2'd0) req[e] = 1'b0;
      mptr = e + 2'd1;
      repeat (3) tick();
      if (k == 0) req[2] = 1'b1;
      repeat (2) tick();
      enc_done = 1'b1; tick(); enc_done = 1'b0;
    end
    req = '0;
    repeat (G + 2) tick();
  endtask

  task automatic test_timeout();
    bit got;
    int s, first;
    logic [1:0] e;
    apply_reset();
    for (int i = 0; i < N; i++) pkt[i] = W'($urandom);
    load_data();
    req = 4'b0010;
    e = pick(req, mptr);
    wait_start(40, got);
    s = cyc;
    n_vec++; if (!got || grant !== (4'b0001 << e)) begin n_err++; $display("FAIL to_grant: got %b want id %0d", grant, e); end
    req = '0; mptr = e + 2'd1;
    first = -1;
    for (int i = 0; i < T + 5; i++) begin
      tick();
      if (first < 0 && timeout_err === 1'b1) first = cyc;
    end
    n_vec++; if (first != s + T) begin n_err++; $display("FAIL to_when: got start+%0d want start+%0d", first - s, T); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_pulse: got %b want 0 after pulse", timeout_err); end
    req = 4'b0100;
    e = pick(req, mptr);
    wait_start(40, got);
    n_vec++; if (!got || grant !== (4'b0001 << e) || enc_data !== pkt[e]) begin n_err++; $display("FAIL to_next: got %b/%h want id %0d data %h", grant, enc_data, e, pkt[e]); end
    req = '0; mptr = e + 2'd1;
    repeat (3) tick();
    enc_done = 1'b1; tick(); enc_done = 1'b0;
    repeat (G + 2) tick();
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [1:0] e;
    apply_reset();
    for (int i = 0; i < N; i++) pkt[i] = W'($urandom);
    load_data();
    req = 4'b1000;
    wait_start(40, got);
    n_vec++; if (!got || grant !== 4'b1000) begin n_err++; $display("FAIL rm_grant3: got %b want 1000", grant); end
    req = '0;
    repeat (5) tick();
    reset = 1'b1; tick();
    n_vec++; if ({grant, enc_start, timeout_err, busy} !== 7'b0) begin n_err++; $display("FAIL rm_outs: got grant=%b start=%b terr=%b busy=%b want all 0", grant, enc_start, timeout_err, busy); end
    n_vec++; if (enc_data !== 8'h00 || active_id !== 2'd0) begin n_err++; $display("FAIL rm_data_id: got %h/%0d want 00/0", enc_data, active_id); end
    reset = 1'b0; mptr = 2'd0;
    req = 4'b1001;
    e = pick(req, mptr);
    wait_start(40, got);
    n_vec++; if (!got || grant !== (4'b0001 << e) || active_id !== e) begin n_err++; $display("FAIL rm_after: got %b/%0d want id %0d", grant, active_id, e); end
    req = 4'b0010; mptr = e + 2'd1;
    tick(); tick(); enc_done = 1'b1; tick(); enc_done = 1'b0;
    e = pick(req, mptr);
    wait_start(40, got);
    n_vec++; if (!got || grant !== (4'b0001 << e)) begin n_err++; $display("FAIL rm_g1: got %b want id %0d", grant, e); end
    req = '0;
    tick(); tick(); enc_done = 1'b1; tick(); enc_done = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; mptr = 2'd0;
    req = 4'b0110;
    e = pick(req, mptr);
    wait_start(40, got);
    n_vec++; if (!got || grant !== (4'b0001 << e)) begin n_err++; $display("FAIL rm_gap_ptr: got %b want id %0d", grant, e); end
    req = '0;
    tick(); enc_done = 1'b1; tick(); enc_done = 1'b0;
    repeat (G + 2) tick();
  endtask

  task automatic test_stale();
    bit got;
    int d, d2;
    logic [1:0] e;
    apply_reset();
    for (int i = 0; i < N; i++) pkt[i] = W'($urandom);
    load_data();
    enc_done = 1'b1; tick(); enc_done = 1'b0; tick();
    n_vec++; if (busy !== 1'b0 || enc_start !== 1'b0) begin n_err++; $display("FAIL st_idle: got busy=%b start=%b want 0/0", busy, enc_start); end
    req = 4'b0001;
    wait_start(40, got);
    req = '0; mptr = 2'd1;
    repeat (3) tick();
    enc_done = 1'b1; d = cyc; tick(); enc_done = 1'b0;
    tick(); enc_done = 1'b1; tick(); enc_done = 1'b0;
    req = 4'b0110;
    repeat (G - 2) tick();
    enc_done = 1'b1;
    e = pick(req, mptr);
    tick(); enc_done = 1'b0;
    n_vec++; if (enc_start !== 1'b1 || cyc != d + G + 2) begin n_err++; $display("FAIL st_gap_len: start=%b at done+%0d want 1 at done+%0d", enc_start, cyc - d, G + 2); end
    n_vec++; if (grant !== (4'b0001 << e)) begin n_err++; $display("FAIL st_grant: got %b want id %0d", grant, e); end
    req[e] = 1'b0; mptr = e + 2'd1;
    repeat (8) tick();
    n_vec++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin n_err++; $display("FAIL st_send: got busy=%b terr=%b want 1/0", busy, timeout_err); end
    enc_done = 1'b1; d2 = cyc; tick(); enc_done = 1'b0;
    e = pick(req, mptr);
    wait_start(40, got);
    n_vec++; if (!got || cyc != d2 + G + 2 || grant !== (4'b0001 << e)) begin n_err++; $display("FAIL st_next: got %b at done+%0d want id %0d at done+%0d", grant, cyc - d2, e, G + 2); end
    req = '0;
    tick(); enc_done = 1'b1; tick(); enc_done = 1'b0;
    repeat (G + 2) tick();
  endtask

  task automatic test_random();
    bit got;
    int prev_d, dly;
    logic [N-1:0] nr;
    logic [1:0] e;
    apply_reset();
    prev_d = -1;
    for (int r = 0; r < 12; r++) begin
      nr = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) if (nr[i] && !req[i]) pkt[i] = W'($urandom);
      load_data();
      req = nr;
      e = pick(req, mptr);
      wait_start(40, got);
      n_vec++; if (!got || grant !== (4'b0001 << e) || active_id !== e) begin n_err++; $display("FAIL rnd_grant%0d: got %b/%0d want id %0d", r, grant, active_id, e); end
      n_vec++; if (enc_data !== pkt[e]) begin n_err++; $display("FAIL rnd_data%0d: got %h want %h", r, enc_data, pkt[e]); end
      if (prev_d >= 0) begin
        n_vec++; if (cyc != prev_d + G + 2) begin n_err++; $display("FAIL rnd_spacing%0d: got done+%0d want done+%0d", r, cyc - prev_d, G + 2); end
      end
      req[e] = 1'b0; mptr = e + 2'd1;
      dly = $urandom_range(1, 20);
      repeat (dly) tick();
      n_vec++; if (enc_data !== pkt[e] || busy !== 1'b1) begin n_err++; $display("FAIL rnd_hold%0d: got %h/%b want %h/1", r, enc_data, busy, pkt[e]); end
      enc_done = 1'b1; prev_d = cyc; tick(); enc_done = 1'b0;
    end
    req = '0;
    repeat (G + 2) tick();
  endtask

  initial begin
    reset = 1'b1; req = '0; enc_done = 1'b0; req_data = '0; mptr = 2'd0;
    test_reset();
    test_single();
    test_all();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_stale();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
